// File: rtl/bcd_display_ctrl_if.sv
// Conversion request/result bundle for bcd_display_ctrl.
// The controller side (slave) takes start/value and returns the packed digits and status.
interface bcd_display_ctrl_if;
  logic        start;
  logic [23:0] value;
  logic [27:0] code;
  logic        busy;
  logic        done;
  logic        ovf;

  modport master (output start, output value, input code, input busy, input done, input ovf);
  modport slave  (input start, input value, output code, output busy, output done, output ovf);
endinterface

// File: rtl/bcd_display_ctrl.sv
// 24-bit binary to 7-digit BCD display controller using serial double-dabble (24 shift cycles).
// Optional macro OVERFLOW_DASH_EN: show all dashes instead of truncated digits on overflow.
module bcd_display_ctrl (
  input  logic              CLK,
  input  logic              RST,
  bcd_display_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, PACK} state_t;

  localparam logic [27:0] DASHES = 28'hAAAAAAA;

  state_t      state_reg;
  logic [23:0] value_reg;
  logic [31:0] scratch_reg;
  logic [4:0]  cnt_reg;
  logic [27:0] code_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        ovf_reg;

  logic [31:0] adj_next;
  logic [31:0] scratch_next;
  logic        ovf_next;
  logic [27:0] code_next;

  // Add-3 correction on every BCD nibble before the shift.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_adj
      assign adj_next[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5)
                                   ? scratch_reg[4*gi +: 4] + 4'd3
                                   : scratch_reg[4*gi +: 4];
    end
  endgenerate

  assign scratch_next = {adj_next[30:0], value_reg[23]};
  assign ovf_next     = |scratch_reg[31:28];

`ifdef OVERFLOW_DASH_EN
  assign code_next = ovf_next ? DASHES : scratch_reg[27:0];
`else
  assign code_next = scratch_reg[27:0];
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= IDLE;
      value_reg   <= '0;
      scratch_reg <= '0;
      cnt_reg     <= '0;
      code_reg    <= DASHES;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      ovf_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            value_reg   <= bus.value;
            scratch_reg <= '0;
            cnt_reg     <= '0;
            busy_reg    <= 1'b1;
            state_reg   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch_reg <= scratch_next;
          value_reg   <= {value_reg[22:0], 1'b0};
          cnt_reg     <= cnt_reg + 5'd1;
          if (cnt_reg == 5'd23) begin
            state_reg <= PACK;
          end
        end
        PACK: begin
          code_reg  <= code_next;
          ovf_reg   <= ovf_next;
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.code = code_reg;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.ovf  = ovf_reg;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Bench for bcd_display_ctrl: arithmetic reference model checked every cycle plus directed literal checks.
module tb_bcd_display_ctrl;

  logic CLK;
  logic RST;

  bcd_display_ctrl_if bus ();

  bcd_display_ctrl dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: expected outputs from decimal arithmetic and the 25-cycle latency.
  int          phase = 0;
  int unsigned held_value = 0;
  logic [27:0] exp_code = 28'hAAAAAAA;
  logic        exp_busy = 1'b0;
  logic        exp_done = 1'b0;
  logic        exp_ovf  = 1'b0;

  function automatic logic [27:0] decimal_code(input int unsigned v);
    logic [27:0] c;
    int unsigned r;
    c = '0;
    r = v % 10000000;
    for (int i = 0; i < 7; i++) begin
      c[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
`ifdef OVERFLOW_DASH_EN
    if (v > 9999999) c = 28'hAAAAAAA;
`endif
    return c;
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      phase    <= 0;
      exp_code <= 28'hAAAAAAA;
      exp_busy <= 1'b0;
      exp_done <= 1'b0;
      exp_ovf  <= 1'b0;
    end else if (phase == 0) begin
      exp_done <= 1'b0;
      if (bus.start) begin
        phase      <= 1;
        held_value <= int'(bus.value);
        exp_busy   <= 1'b1;
      end
    end else if (phase == 25) begin
      phase    <= 0;
      exp_busy <= 1'b0;
      exp_done <= 1'b1;
      exp_ovf  <= (held_value > 9999999);
      exp_code <= decimal_code(held_value);
    end else begin
      phase <= phase + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(posedge CLK);
      #1;
      check("model_busy", 32'(bus.busy), 32'(exp_busy));
      check("model_done", 32'(bus.done), 32'(exp_done));
      check("model_ovf",  32'(bus.ovf),  32'(exp_ovf));
      check("model_code", 32'(bus.code), 32'(exp_code));
    end
  endtask

  // One conversion: pulse start, scramble value while busy, wait (bounded) for done.
  task automatic run_conv(input logic [23:0] v, output int latency);
    int n;
    @(negedge CLK);
    bus.start = 1'b1;
    bus.value = v;
    @(negedge CLK);
    bus.start = 1'b0;
    bus.value = 24'($urandom);
    n = 1;
    latency = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK);
      #1;
      if (bus.done) begin
        latency = n;
        break;
      end
      n++;
    end
    if (latency < 0) check("done_timeout", 32'd0, 32'd1);
    $display("conv value=%0d code=%07h ovf=%0b latency=%0d", v, bus.code, bus.ovf, latency);
  endtask

  initial begin
    int lat;
    int rises;
    int last_rise;
    int cyc;
    int dones;
    logic prev_busy;

    RST       = 1'b1;
    bus.start = 1'b0;
    bus.value = '0;
    fork
      compare_loop();
    join_none
    repeat (3) @(negedge CLK);
    check("reset_code", 32'(bus.code), 32'h0AAAAAAA);
    check("reset_busy", 32'(bus.busy), 32'd0);
    RST = 1'b0;

    // Scenario 1
    run_conv(24'd1234567, lat);
    check("s1_latency", 32'(lat), 32'd25);
    check("s1_code", 32'(bus.code), 32'h01234567);
    check("s1_ovf", 32'(bus.ovf), 32'd0);

    // Scenario 2
    run_conv(24'd0, lat);
    check("s2a_code", 32'(bus.code), 32'h00000000);
    run_conv(24'd9999999, lat);
    check("s2b_code", 32'(bus.code), 32'h09999999);
    check("s2b_ovf", 32'(bus.ovf), 32'd0);

    // Scenario 3
    run_conv(24'd16777215, lat);
    check("s3_ovf", 32'(bus.ovf), 32'd1);
`ifdef OVERFLOW_DASH_EN
    check("s3_code", 32'(bus.code), 32'h0AAAAAAA);
`else
    check("s3_code", 32'(bus.code), 32'h06777215);
`endif
    run_conv(24'd10000000, lat);
    check("s3b_ovf", 32'(bus.ovf), 32'd1);

    // Scenario 4: start held high
    @(negedge CLK);
    bus.start = 1'b1;
    bus.value = 24'd42;
    rises = 0;
    last_rise = 0;
    prev_busy = 1'b0;
    for (cyc = 1; cyc <= 80; cyc++) begin
      @(posedge CLK);
      #1;
      if (bus.busy && !prev_busy) begin
        if (rises > 0) check("s4_spacing", 32'(cyc - last_rise), 32'd26);
        rises++;
        last_rise = cyc;
      end
      prev_busy = bus.busy;
    end
    check("s4_rises", 32'(rises), 32'd4);
    @(negedge CLK);
    bus.start = 1'b0;
    for (int i = 0; i < 40 && bus.busy; i++) @(negedge CLK);
    check("s4_idle", 32'(bus.busy), 32'd0);
    check("s4_code", 32'(bus.code), 32'h00000042);

    // Scenario 5: reset mid-conversion
    @(negedge CLK);
    bus.start = 1'b1;
    bus.value = 24'd555;
    @(negedge CLK);
    bus.start = 1'b0;
    repeat (9) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("s5_code_rst", 32'(bus.code), 32'h0AAAAAAA);
    check("s5_busy_rst", 32'(bus.busy), 32'd0);
    dones = 0;
    repeat (30) begin
      @(posedge CLK);
      #1;
      if (bus.done) dones++;
    end
    check("s5_no_done", 32'(dones), 32'd0);
    run_conv(24'd555, lat);
    check("s5_code", 32'(bus.code), 32'h00000555);

    // Scenario 6: reset wins over start
    @(negedge CLK);
    RST = 1'b1;
    bus.start = 1'b1;
    bus.value = 24'd7;
    @(posedge CLK);
    #1;
    check("s6_busy_a", 32'(bus.busy), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    bus.start = 1'b0;
    @(posedge CLK);
    #1;
    check("s6_busy_b", 32'(bus.busy), 32'd0);
    check("s6_code", 32'(bus.code), 32'h0AAAAAAA);

    repeat (2) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bcd_display_ctrl.md
BCD_DISPLAY_CTRL -- requirements
Module: bcd_display_ctrl

Interface
REQ-001 The block SHALL have no parameters; its width is fixed at 7 digits, with a 24-bit binary input and a 28-bit packed code output.
REQ-002 CLK  input  1  single clock; all state SHALL update on posedge CLK.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  conversion request, sampled only in IDLE.
REQ-005 value  input  24  unsigned binary value to display, latched when start is accepted.
REQ-006 code  output  28  registered packed digits; nibble [4i+3:4i] is digit i (i=0 is least significant); 4'hA is the dash code; the bus drives the 7-segment decoder directly.
REQ-007 busy  output  1  high while a conversion is in progress (SHIFT or PACK).
REQ-008 done  output  1  single-cycle pulse when code is updated.
REQ-009 ovf  output  1  registered; high when the last converted value exceeded 9,999,999.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, SHIFT and PACK.
REQ-011 In IDLE with start=1 at edge k: latch value, clear the 32-bit BCD scratch, set the iteration counter to 0, go to SHIFT, and set busy=1 after the edge.
REQ-012 In SHIFT, each cycle SHALL perform one double-dabble iteration: add 3 to every scratch nibble >= 5, then shift {scratch, value_reg} left by 1.
REQ-013 SHIFT SHALL last exactly 24 cycles (edges k+1..k+24), then go to PACK.
REQ-014 At edge k+25 (PACK): update code and ovf, pulse done=1 for one cycle, set busy=0, return to IDLE.
REQ-015 Latency SHALL be 25 cycles from start acceptance to done; minimum start-to-start spacing is 26 cycles.
REQ-016 start SHALL be ignored in SHIFT and PACK; it is not queued.
REQ-017 code and ovf SHALL hold their values between conversions; intermediate scratch SHALL never appear on code.
REQ-018 ovf SHALL be set when the eighth BCD digit (scratch[31:28]) is non-zero, and cleared otherwise.
REQ-019 Every nibble written to code SHALL be in the range 0-9 or equal to 4'hA.
REQ-020 value is sampled only at acceptance; changes to value during a conversion SHALL have no effect.

Reset
REQ-021 While RST=1 at an edge, the block SHALL go to IDLE, with busy=0, done=0, ovf=0, code=28'hAAAAAAA (all dashes), and the counter and scratch cleared.
REQ-022 RST SHALL take priority over start.
REQ-023 RST asserted mid-conversion SHALL abort it with no done pulse; the next conversion requires a fresh start after RST deasserts.

Configuration
REQ-024 The macro OVERFLOW_DASH_EN SHALL select overflow display behaviour.
REQ-025 With OVERFLOW_DASH_EN defined: when ovf is set in PACK, code SHALL be 28'hAAAAAAA.
REQ-026 Without OVERFLOW_DASH_EN: code SHALL be scratch[27:0], i.e. the lower 7 digits (truncation); ovf SHALL still be reported.

Verification
REQ-027 Scenario 1: value=1234567 with a 1-cycle start -> busy high for 25 cycles; done pulses 25 cycles after acceptance; code=28'h1234567, ovf=0.
REQ-028 Scenario 2: value=0, then value=9999999 back-to-back, each start issued when IDLE -> code=28'h0000000, then code=28'h9999999, ovf=0 for both.
REQ-029 Scenario 3: value=16777215 -> ovf=1; code=28'hAAAAAAA with OVERFLOW_DASH_EN, code=28'h6777215 without.
REQ-030 Scenario 4: start held high continuously with value=42 -> conversions begin at exactly 26-cycle spacing; code=28'h0000042; no start accepted while busy=1.
REQ-031 Scenario 5: RST pulsed 10 cycles into a conversion of value=555 -> no done pulse; code=28'hAAAAAAA, busy=0; the following start then yields code=28'h0000555.
REQ-032 Scenario 6: RST and start both high at the same edge -> block stays in IDLE with busy=0.
